systolic_fp8_seq: RTL and testbench
===================================

Name: systolic_fp8_seq

Overview:
Sequencer that drives one N×N FP8 systolic array tile computation.
- Clears the array accumulators.
- Streams K operand slices from an external operand buffer: one A column and one B row per cycle.
- Applies the per-lane diagonal skew the array requires and zero-fills idle lanes.
- Waits out the array fill/drain latency and then pulses done/c_valid so the result bus can be captured.
- Sits between the operand SRAM/buffers and systolic_fp8.

Parameters:
- N, 16, array dimension (lanes per operand bus).
- K_MAX, 256, maximum reduction length per job.
- K_W, 8, address width, equal to clog2(K_MAX).
- DRAIN_CYC, 2*N, cycles between the last operand read and done.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, job request; sampled only in IDLE.
- k_len, input, K_W+1, reduction length; sampled with start.
- busy, output, 1, job in progress.
- done, output, 1, one-cycle completion pulse.
- c_valid, output, 1, array C_bus holds the final tile this cycle (identical timing to done).
- mem_rd_en, output, 1, operand buffer read strobe.
- mem_rd_addr, output, K_W, slice index k.
- a_rd_data, input, 8*N, A[:,k]; lane i in bits [8i+7:8i]; valid 1 cycle after mem_rd_en.
- b_rd_data, input, 8*N, B[k,:]; same lane packing and latency as a_rd_data.
- arr_clr_n, output, 1, active-low clear to the array's rst_n.
- a_bus, output, 8*N, skewed A lanes to the array.
- b_bus, output, 8*N, skewed B lanes to the array.

Behaviour:
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: start=1 latches k_len and moves to CLEAR. start in any other state is ignored; it is neither queued nor an error.
- k_len clamping: k_len > K_MAX is clamped to K_MAX when latched.
- k_len = 0: CLEAR goes directly to DONE. No reads are issued and there is no drain.
- CLEAR: exactly 1 cycle; arr_clr_n=0; next state is FEED (or DONE when k_len=0).
- FEED: exactly k_len cycles with mem_rd_en=1. mem_rd_addr = 0,1,...,k_len-1, from a K_W-bit counter reset on entry.
- DRAIN: exactly DRAIN_CYC cycles with mem_rd_en=0. A drain counter is loaded on entry.
- DONE: exactly 1 cycle with done=c_valid=1; next state is IDLE.
- busy=1 in CLEAR, FEED, DRAIN and DONE; busy=0 in IDLE.
- Cycle numbering (start sampled at cycle 0):
  - CLEAR at cycle 1.
  - FEED at cycles 2..k_len+1.
  - DRAIN at cycles k_len+2..k_len+DRAIN_CYC+1.
  - done at cycle k_len+DRAIN_CYC+2.
- Skew:
  - Lane i of a_bus/b_bus = (a|b)_rd_data lane i delayed by i registers. Lane 0 is combinational from rd_data.
  - rd_data lanes are qualified by a 1-cycle-delayed copy of mem_rd_en. Unqualified lanes inject 8'h00.
  - Delayed lanes carry the qualified, zero-filled values, so every lane outputs 8'h00 whenever no valid slice occupies that stage.
  - Slice k therefore appears on lane i at cycle k+3+i.
- Reset (rst_n=0 at a clock edge, including mid-job):
  - State returns to IDLE, and all counters and skew registers are cleared to 0.
  - busy=0, done=0, c_valid=0, mem_rd_en=0, mem_rd_addr=0.
  - arr_clr_n = rst_n & (state!=CLEAR), so the array is held cleared for the duration of reset.
- Simultaneous events:
  - start arriving in the same cycle as done: ignored (state is DONE, not IDLE).
  - start on the first IDLE cycle after DONE: accepted.
- No backpressure exists. The operand buffer must return data at the fixed 1-cycle latency.

Decomposition:
- Package fp8_sa_pkg holds:
  - FP8_W=8.
  - The state enum seq_state_t {IDLE, CLEAR, FEED, DRAIN, DONE}.
  - Helper function drain_cycles(N) returning 2*N.
- Sub-module sa_skew_line #(W=8, DEPTH):
  - DEPTH-stage register chain, synchronous active-low clear.
  - DEPTH=0 is a passthrough.
  - Instantiated 2N times via generate, with DEPTH=i for lane i.

Test Plan:
- Basic job, N=4, k_len=3, start at cycle 0 -> arr_clr_n=0 at cycle 1 only; mem_rd_addr 0,1,2 at cycles 2-4; done=c_valid=1 only at cycle 13; busy high cycles 1-13.
- Skew check, N=4, a_rd_data lane i of slice k = 8'h{k,i} -> a_bus lane 3 shows 8'h03,8'h13,8'h23 at cycles 6,7,8; 8'h00 at all other cycles.
- k_len=0 -> CLEAR at cycle 1, done at cycle 2; mem_rd_en never asserted.
- k_len=K_MAX+5 -> exactly K_MAX reads (addr 0..K_MAX-1); done at cycle K_MAX+DRAIN_CYC+2.
- Mid-FEED reset (rst_n=0 at cycle 4 of a k_len=8 job) -> next cycle busy=0, mem_rd_en=0, all a_bus/b_bus lanes 8'h00, arr_clr_n=0 during reset; a new start then completes normally.
- start held high continuously through a job -> second job begins exactly 1 cycle after done (IDLE, then CLEAR); no start is accepted during busy.

Source files
------------

// File: rtl/fp8_sa_pkg.sv
// Shared types and constants for the FP8 systolic array sequencer.
package fp8_sa_pkg;

    localparam int FP8_W = 8;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} seq_state_t;

    function automatic int drain_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth register delay line with synchronous active-low clear.
// DEPTH=0 degenerates to a wire so lane 0 needs no special casing upstream.
module sa_skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, clr_n};
            assign q = d;
        end else begin : g_chain
            logic [DEPTH-1:0][W-1:0] stage;
            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    stage <= '0;
                end else begin
                    stage[0] <= d;
                    for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
                end
            end
            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_fp8_seq.sv
// Job sequencer for one NxN FP8 systolic tile: clear, stream K operand slices
// with per-lane diagonal skew, wait out fill/drain, then flag the result.
module systolic_fp8_seq
    import fp8_sa_pkg::*;
#(
    parameter int N         = 16,
    parameter int K_MAX     = 256,
    parameter int K_W       = 8,
    parameter int DRAIN_CYC = drain_cycles(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [K_W:0]     k_len,
    output logic             busy,
    output logic             done,
    output logic             c_valid,
    output logic             mem_rd_en,
    output logic [K_W-1:0]   mem_rd_addr,
    input  logic [8*N-1:0]   a_rd_data,
    input  logic [8*N-1:0]   b_rd_data,
    output logic             arr_clr_n,
    output logic [8*N-1:0]   a_bus,
    output logic [8*N-1:0]   b_bus
);

    localparam int             DW     = $clog2(DRAIN_CYC + 1);
    localparam logic [K_W:0]   KMAX_V = (K_W + 1)'(K_MAX);

    seq_state_t        state;
    logic [K_W:0]      k_lat;
    logic [K_W-1:0]    addr;
    logic [DW-1:0]     drain_cnt;
    logic              rd_en_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_lat     <= '0;
            addr      <= '0;
            drain_cnt <= '0;
            rd_en_d   <= 1'b0;
        end else begin
            // Read data lags the strobe by one cycle; this qualifies it.
            rd_en_d <= (state == FEED);
            case (state)
                IDLE: if (start) begin
                    state <= CLEAR;
                    k_lat <= (k_len > KMAX_V) ? KMAX_V : k_len;
                end
                CLEAR: begin
                    addr  <= '0;
                    state <= (k_lat == '0) ? DONE : FEED;
                end
                FEED: begin
                    if ({1'b0, addr} == k_lat - (K_W + 1)'(1)) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYC - 1);
                    end else begin
                        addr <= addr + K_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= DONE;
                    else                 drain_cnt <= drain_cnt - DW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign c_valid     = (state == DONE);
    assign mem_rd_en   = (state == FEED);
    assign mem_rd_addr = addr;
    // Reset also holds the array cleared, not just the CLEAR state.
    assign arr_clr_n   = rst_n & (state != CLEAR);

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [FP8_W-1:0] a_q, b_q;
        assign a_q = rd_en_d ? a_rd_data[i*FP8_W +: FP8_W] : '0;
        assign b_q = rd_en_d ? b_rd_data[i*FP8_W +: FP8_W] : '0;

        sa_skew_line #(.W(FP8_W), .DEPTH(i)) u_skew_a (
            .clk   (clk),
            .clr_n (rst_n),
            .d     (a_q),
            .q     (a_bus[i*FP8_W +: FP8_W])
        );
        sa_skew_line #(.W(FP8_W), .DEPTH(i)) u_skew_b (
            .clk   (clk),
            .clr_n (rst_n),
            .d     (b_q),
            .q     (b_bus[i*FP8_W +: FP8_W])
        );
    end

endmodule

// File: tb/tb_systolic_fp8_seq.sv
// Randomized scoreboard bench for systolic_fp8_seq (N=4): expected reads,
// done pulses and per-cycle skewed bus contents come from a job timeline model.
module tb_systolic_fp8_seq;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int K_W   = 8;
    localparam int DRAIN = 2 * N;
    localparam int W     = 8 * N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [K_W:0]   k_len = '0;
    logic           busy, done, c_valid, mem_rd_en, arr_clr_n;
    logic [K_W-1:0] mem_rd_addr;
    logic [W-1:0]   a_rd_data = '0, b_rd_data = '0;
    logic [W-1:0]   a_bus, b_bus;

    systolic_fp8_seq #(.N(N), .K_MAX(K_MAX), .K_W(K_W), .DRAIN_CYC(DRAIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .c_valid    (c_valid),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .a_rd_data  (a_rd_data),
        .b_rd_data  (b_rd_data),
        .arr_clr_n  (arr_clr_n),
        .a_bus      (a_bus),
        .b_bus      (b_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int addr; } rd_t;

    int          checks = 0, errors = 0;
    rd_t         exp_rd[$];
    int          exp_done[$];
    logic [W-1:0] exp_a[int], exp_b[int];
    logic [W-1:0] amem [K_MAX], bmem [K_MAX];
    int          busy_lo = -100, busy_hi = -100, idle_from = 0;
    logic        prev_rd = 1'b0;
    logic [K_W-1:0] prev_addr = '0;
    int          jobs = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) w[i*8 +: 8] = 8'($urandom);
        return w;
    endfunction

    // Job accepted at cycle s: CLEAR s+1, reads s+2.., slice j on lane i at s+j+3+i.
    task automatic accept(input int s, input int k);
        int kk, dc, key;
        logic [W-1:0] v;
        kk = (k > K_MAX) ? K_MAX : k;
        dc = (kk == 0) ? s + 2 : s + kk + DRAIN + 2;
        busy_lo = s + 1;
        busy_hi = dc;
        idle_from = dc + 1;
        jobs++;
        exp_done.push_back(dc);
        for (int j = 0; j < kk; j++) begin
            amem[j] = rand_word();
            bmem[j] = rand_word();
            exp_rd.push_back('{c: s + 2 + j, addr: j});
            for (int i = 0; i < N; i++) begin
                key = s + j + 3 + i;
                v = exp_a.exists(key) ? exp_a[key] : '0;
                v[i*8 +: 8] = amem[j][i*8 +: 8];
                exp_a[key] = v;
                v = exp_b.exists(key) ? exp_b[key] : '0;
                v[i*8 +: 8] = bmem[j][i*8 +: 8];
                exp_b[key] = v;
            end
        end
    endtask

    // Reset sampled at the end of cycle c aborts everything scheduled after c.
    task automatic reset_model(input int c);
        int keys[$];
        if (busy_hi > c) busy_hi = c;
        idle_from = c + 1;
        while (exp_rd.size() > 0 && exp_rd[$].c > c) void'(exp_rd.pop_back());
        while (exp_done.size() > 0 && exp_done[$] > c) void'(exp_done.pop_back());
        foreach (exp_a[key]) if (key > c) keys.push_back(key);
        foreach (keys[n]) begin
            exp_a.delete(keys[n]);
            exp_b.delete(keys[n]);
        end
    endtask

    task automatic step(input logic st, input int k, input logic r);
        @(negedge clk);
        a_rd_data = prev_rd ? amem[prev_addr] : rand_word();
        b_rd_data = prev_rd ? bmem[prev_addr] : rand_word();
        prev_rd   = mem_rd_en;
        prev_addr = mem_rd_addr;
        start = st;
        k_len = (K_W + 1)'(k);
        rst_n = r;
        if (!r)                          reset_model(cyc);
        else if (st && cyc >= idle_from) accept(cyc, k);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cyc < idle_from + 1 || exp_done.size() > 0) && n < 2000) begin
            step(1'b0, 0, 1'b1);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 1, 0);
    endtask

    // Monitor: sample away from the active edge and compare against the scoreboard.
    initial begin
        logic [W-1:0] ea, eb;
        int c;
        forever begin
            @(negedge clk);
            #2;
            c  = cyc;
            ea = exp_a.exists(c) ? exp_a[c] : '0;
            eb = exp_b.exists(c) ? exp_b[c] : '0;
            check("busy", busy, (c >= busy_lo && c <= busy_hi));
            check("arr_clr_n", arr_clr_n, rst_n && (c != busy_lo));
            check("a_bus", a_bus, ea);
            check("b_bus", b_bus, eb);
            check("c_valid_eq_done", c_valid, done);
            if (mem_rd_en) begin
                if (exp_rd.size() > 0 && exp_rd[0].c == c) begin
                    check("rd_addr", mem_rd_addr, exp_rd[0].addr);
                    void'(exp_rd.pop_front());
                end else begin
                    check("rd_unexpected", 1, 0);
                end
            end else if (exp_rd.size() > 0 && exp_rd[0].c <= c) begin
                check("rd_missing", 0, 1);
                void'(exp_rd.pop_front());
            end
            if (done) begin
                if (exp_done.size() > 0 && exp_done[0] == c) begin
                    check("done_cycle", c, exp_done[0]);
                    void'(exp_done.pop_front());
                end else begin
                    check("done_unexpected", 1, 0);
                end
            end else if (exp_done.size() > 0 && exp_done[0] <= c) begin
                check("done_missing", 0, 1);
                void'(exp_done.pop_front());
            end
        end
    end

    initial begin
        int s;
        repeat (3) step(1'b0, 0, 1'b0);
        repeat (2) step(1'b0, 0, 1'b1);

        // basic, empty and clamped jobs
        step(1'b1, 3, 1'b1);
        wait_idle();
        step(1'b1, 0, 1'b1);
        wait_idle();
        step(1'b1, K_MAX + 5, 1'b1);
        wait_idle();

        // reset four cycles into a k_len=8 job, then a clean job
        step(1'b1, 8, 1'b1);
        repeat (3) step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 5, 1'b1);
        wait_idle();

        // start held high: back-to-back jobs, none accepted while busy
        s = jobs;
        for (int n = 0; n < 200 && jobs < s + 4; n++)
            step(1'b1, $urandom_range(0, 20), 1'b1);
        check("held_start_jobs", jobs - s, 4);
        step(1'b0, 0, 1'b1);
        wait_idle();

        // random start pulses, lengths and occasional resets
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 40),
                 $urandom_range(0, 149) != 0);
        step(1'b0, 0, 1'b1);
        wait_idle();
        repeat (3) step(1'b0, 0, 1'b1);

        check("rd_queue_empty", exp_rd.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
